conv3x3_stream_engine: RTL and testbench

//  Streaming 3x3 convolution engine. Input is a zero-padded image, row-major, PIX_PER_WORD pixels per AXI word.

---
 rtl/conv_pkg.sv | 58 +++++
 rtl/conv3x3_mac.sv | 76 +++++++
 rtl/conv3x3_stream_engine.sv | 212 +++++++++++++++++++++
 tb/tb_conv3x3_stream_engine.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 streaming convolution engine: default
// Q-format widths, derived-width helpers, the saturation test and the
// control FSM encoding.
package conv_pkg;

    localparam int DEF_NB_PIXEL     = 8;
    localparam int DEF_NBF_PIXEL    = 7;
    localparam int DEF_PIX_PER_WORD = 4;
    localparam int DEF_IMAGE_WIDTH  = 200;
    localparam int DEF_IMAGE_HEIGHT = 200;
    localparam int DEF_NB_COEFF     = 8;
    localparam int DEF_NBF_COEFF    = 7;
    localparam int DEF_NB_OUTPUT    = 8;
    localparam int DEF_NBF_OUTPUT   = 7;

    // Control FSM encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // Full-precision pixel x coefficient product width (NB_PROD).
    function automatic int prod_width(input int nb_pixel, input int nb_coeff);
        return nb_pixel + nb_coeff;
    endfunction

    // Nine products need 4 guard bits so the sum can never wrap (NB_ADD).
    function automatic int add_width(input int nb_prod);
        return nb_prod + 4;
    endfunction

    // Fractional bits dropped when rescaling the sum to the output format.
    function automatic int shift_amount(input int nbf_pixel, input int nbf_coeff,
                                        input int nbf_output);
        return nbf_pixel + nbf_coeff - nbf_output;
    endfunction

    // Width of the rescaled sum before saturation (NB_SAT).
    function automatic int sat_width(input int nb_add, input int shift);
        return nb_add - shift;
    endfunction

    // Largest positive coefficient: the closest Q-format value to 1.0.
    function automatic int coeff_identity(input int nbf_coeff);
        return (1 << nbf_coeff) - 1;
    endfunction

    // Saturation test against a signed nb_out-bit range.
    // Returns {below_min, above_max}; both zero means the value fits.
    function automatic logic [1:0] saturate_flags(input logic signed [63:0] value,
                                                  input int nb_out);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (nb_out - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (nb_out - 1));
        return {value < min_v, value > max_v};
    endfunction

endpackage

// File: rtl/conv3x3_mac.sv
// One output lane: 3x3 window times kernel, summed, rescaled and saturated.
// Stage 1 registers the nine products, stage 2 registers the final result.
// Window/kernel tap i sits at [i*width +: width], i = row*3 + col, row 0 = top.
module conv3x3_mac
    import conv_pkg::*;
#(
    parameter int NB_PIXEL   = DEF_NB_PIXEL,
    parameter int NBF_PIXEL  = DEF_NBF_PIXEL,
    parameter int NB_COEFF   = DEF_NB_COEFF,
    parameter int NBF_COEFF  = DEF_NBF_COEFF,
    parameter int NB_OUTPUT  = DEF_NB_OUTPUT,
    parameter int NBF_OUTPUT = DEF_NBF_OUTPUT
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [9*NB_PIXEL-1:0] i_window,
    input  logic [9*NB_COEFF-1:0] i_kernel,
    output logic [NB_OUTPUT-1:0]  o_result
);

    localparam int NB_PROD = prod_width(NB_PIXEL, NB_COEFF);
    localparam int NB_ADD  = add_width(NB_PROD);
    localparam int SHIFT   = shift_amount(NBF_PIXEL, NBF_COEFF, NBF_OUTPUT);
    localparam int NB_SAT  = sat_width(NB_ADD, SHIFT);

    logic signed [NB_PROD-1:0] prod_d [9];
    logic signed [NB_PROD-1:0] prod_q [9];
    logic signed [NB_ADD-1:0]  sum_d;
    logic signed [NB_SAT-1:0]  scaled_d;
    logic [1:0]                sat_flags_d;
    logic [NB_OUTPUT-1:0]      result_d;
    logic [NB_OUTPUT-1:0]      result_q;

    // Stage 1: nine signed products at full precision.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            prod_d[i] = NB_PROD'($signed(i_window[i*NB_PIXEL +: NB_PIXEL]))
                      * NB_PROD'($signed(i_kernel[i*NB_COEFF +: NB_COEFF]));
        end
    end

    // Stage 2: sum, arithmetic shift (floor toward -inf), then clamp.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < 9; i++) begin
            sum_d = sum_d + NB_ADD'(prod_q[i]);
        end
        scaled_d    = NB_SAT'(sum_d >>> SHIFT);
        sat_flags_d = saturate_flags(64'(scaled_d), NB_OUTPUT);
        if (sat_flags_d[0]) begin
            result_d = {1'b0, {(NB_OUTPUT-1){1'b1}}};
        end else if (sat_flags_d[1]) begin
            result_d = {1'b1, {(NB_OUTPUT-1){1'b0}}};
        end else begin
            result_d = scaled_d[NB_OUTPUT-1:0];
        end
    end

    // Pipeline registers for both stages.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 9; i++) begin
                prod_q[i] <= '0;
            end
            result_q <= '0;
        end else begin
            for (int i = 0; i < 9; i++) begin
                prod_q[i] <= prod_d[i];
            end
            result_q <= result_d;
        end
    end

    assign o_result = result_q;

endmodule

// File: rtl/conv3x3_stream_engine.sv
// Streaming 3x3 convolution over a pre-padded image, PIX_PER_WORD pixels per
// word. Two word-wide line buffers hold the two rows above the incoming one;
// a per-row "previous word" register plus lanes 0..1 of the current word
// give every lane its three-column window. Kernel is double-buffered and
// committed on start-of-frame.
module conv3x3_stream_engine
    import conv_pkg::*;
#(
    parameter int NB_PIXEL     = DEF_NB_PIXEL,
    parameter int NBF_PIXEL    = DEF_NBF_PIXEL,
    parameter int PIX_PER_WORD = DEF_PIX_PER_WORD,
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int NB_COEFF     = DEF_NB_COEFF,
    parameter int NBF_COEFF    = DEF_NBF_COEFF,
    parameter int NB_OUTPUT    = DEF_NB_OUTPUT,
    parameter int NBF_OUTPUT   = DEF_NBF_OUTPUT
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic                              i_valid,
    input  logic                              i_sof,
    input  logic [NB_PIXEL*PIX_PER_WORD-1:0]  i_data,
    input  logic                              i_coeff_we,
    input  logic [3:0]                        i_coeff_addr,
    input  logic [NB_COEFF-1:0]               i_coeff_data,
    output logic                              o_valid,
    output logic                              o_last,
    output logic [NB_OUTPUT*PIX_PER_WORD-1:0] o_data
);

    localparam int P       = PIX_PER_WORD;
    localparam int W       = IMAGE_WIDTH / P;
    localparam int NB_WORD = NB_PIXEL * P;
    localparam int NB_COL  = (W > 1) ? $clog2(W) : 1;
    localparam int NB_ROW  = $clog2(IMAGE_HEIGHT);

    localparam logic [NB_COL-1:0]   LAST_WORD = NB_COL'(W - 1);
    localparam logic [NB_ROW-1:0]   LAST_ROW  = NB_ROW'(IMAGE_HEIGHT - 1);
    localparam logic [NB_ROW-1:0]   RUN_ROW   = NB_ROW'(2);
    localparam logic [NB_COEFF-1:0] COEFF_ID  = NB_COEFF'(coeff_identity(NBF_COEFF));

    // Control state
    logic [1:0]        state_q, state_d;
    logic [NB_ROW-1:0] row_q, row_d, cur_row;
    logic [NB_COL-1:0] word_q, word_d, cur_word;
    logic              sof_hit, accept, emit, frame_end;
    logic              word_is_last, row_is_last;

    // Kernel banks
    logic [NB_COEFF-1:0]   shadow_q [9];
    logic [NB_COEFF-1:0]   shadow_d [9];
    logic [NB_COEFF-1:0]   active_q [9];
    logic [NB_COEFF-1:0]   active_d [9];
    logic [9*NB_COEFF-1:0] kernel_flat;

    // Line buffers (row r-2 and row r-1) and previous-word registers
    logic [NB_WORD-1:0] lb_top_mem [W];
    logic [NB_WORD-1:0] lb_mid_mem [W];
    logic [NB_WORD-1:0] lb_top_rd, lb_mid_rd;
    logic [NB_WORD-1:0] prev_top_q, prev_top_d;
    logic [NB_WORD-1:0] prev_mid_q, prev_mid_d;
    logic [NB_WORD-1:0] prev_bot_q, prev_bot_d;
    logic [(P+2)*NB_PIXEL-1:0] ext_top, ext_mid, ext_bot;

    // Output-control pipe, aligned with the two MAC stages
    logic valid_s1_q, valid_s1_d, valid_s2_q;
    logic last_s1_q, last_s1_d, last_s2_q;

    // Word acceptance and position; a sof word always lands at (row 0, word 0).
    always_comb begin
        sof_hit      = i_valid & i_sof;
        accept       = i_valid & (i_sof | (state_q != ST_IDLE));
        cur_row      = sof_hit ? '0 : row_q;
        cur_word     = sof_hit ? '0 : word_q;
        word_is_last = (cur_word == LAST_WORD);
        row_is_last  = (cur_row == LAST_ROW);
        emit         = accept & ~sof_hit & (state_q == ST_RUN) & (cur_word != '0);
        frame_end    = emit & word_is_last & row_is_last;
    end

    // FSM and row/word counters; nothing moves on cycles without an accepted word.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        word_d  = word_q;
        if (accept) begin
            if (word_is_last) begin
                word_d = '0;
                row_d  = cur_row + 1'b1;
            end else begin
                word_d = cur_word + 1'b1;
                row_d  = cur_row;
            end
            if (sof_hit) begin
                state_d = ST_FILL;
            end else if ((state_q == ST_FILL) && (cur_row == RUN_ROW)) begin
                state_d = ST_RUN;
            end else if ((state_q == ST_RUN) && word_is_last && row_is_last) begin
                state_d = ST_IDLE;
                row_d   = '0;
                word_d  = '0;
            end
        end
    end

    // Shadow bank takes writes any cycle; the active bank copies it (including a
    // same-cycle write) only on start-of-frame.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            shadow_d[i] = (i_coeff_we && (i_coeff_addr == 4'(i))) ? i_coeff_data
                                                                 : shadow_q[i];
            active_d[i] = sof_hit ? shadow_d[i] : active_q[i];
        end
    end

    // Flatten the active kernel for the lane MACs.
    always_comb begin
        kernel_flat = '0;
        for (int i = 0; i < 9; i++) begin
            kernel_flat[i*NB_COEFF +: NB_COEFF] = active_q[i];
        end
    end

    // Line buffers are read combinationally so the window is ready in the
    // acceptance cycle; this keeps the input-to-output latency at two stages.
    always_comb begin
        lb_top_rd  = lb_top_mem[cur_word];
        lb_mid_rd  = lb_mid_mem[cur_word];
        prev_top_d = accept ? lb_top_rd : prev_top_q;
        prev_mid_d = accept ? lb_mid_rd : prev_mid_q;
        prev_bot_d = accept ? i_data    : prev_bot_q;
        valid_s1_d = emit;
        last_s1_d  = frame_end;
    end

    // Rows shift down one buffer as each new word arrives (read-before-write).
    always_ff @(posedge i_clk) begin
        if (accept) begin
            lb_top_mem[cur_word] <= lb_mid_rd;
            lb_mid_mem[cur_word] <= i_data;
        end
    end

    // Control, kernel and pipeline registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            word_q     <= '0;
            prev_top_q <= '0;
            prev_mid_q <= '0;
            prev_bot_q <= '0;
            valid_s1_q <= 1'b0;
            valid_s2_q <= 1'b0;
            last_s1_q  <= 1'b0;
            last_s2_q  <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                shadow_q[i] <= (i == 4) ? COEFF_ID : '0;
                active_q[i] <= (i == 4) ? COEFF_ID : '0;
            end
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            word_q     <= word_d;
            prev_top_q <= prev_top_d;
            prev_mid_q <= prev_mid_d;
            prev_bot_q <= prev_bot_d;
            valid_s1_q <= valid_s1_d;
            valid_s2_q <= valid_s1_q;
            last_s1_q  <= last_s1_d;
            last_s2_q  <= last_s1_q;
            for (int i = 0; i < 9; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    // Extended rows: previous word plus the first two pixels of the current one.
    assign ext_top = {lb_top_rd[2*NB_PIXEL-1:0], prev_top_q};
    assign ext_mid = {lb_mid_rd[2*NB_PIXEL-1:0], prev_mid_q};
    assign ext_bot = {i_data[2*NB_PIXEL-1:0],    prev_bot_q};

    generate
        for (genvar gi = 0; gi < P; gi++) begin : g_lane
            logic [9*NB_PIXEL-1:0] window;
            assign window = {ext_bot[gi*NB_PIXEL +: 3*NB_PIXEL],
                             ext_mid[gi*NB_PIXEL +: 3*NB_PIXEL],
                             ext_top[gi*NB_PIXEL +: 3*NB_PIXEL]};

            conv3x3_mac #(
                .NB_PIXEL   (NB_PIXEL),
                .NBF_PIXEL  (NBF_PIXEL),
                .NB_COEFF   (NB_COEFF),
                .NBF_COEFF  (NBF_COEFF),
                .NB_OUTPUT  (NB_OUTPUT),
                .NBF_OUTPUT (NBF_OUTPUT)
            ) u_mac (
                .i_clk    (i_clk),
                .i_reset  (i_reset),
                .i_window (window),
                .i_kernel (kernel_flat),
                .o_result (o_data[gi*NB_OUTPUT +: NB_OUTPUT])
            );
        end
    endgenerate

    assign o_valid = valid_s2_q;
    assign o_last  = last_s2_q;

endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// Directed bench for conv3x3_stream_engine on a 8x4 padded image, 4 lanes.
module tb_conv3x3_stream_engine;

    localparam int P  = 4;
    localparam int IW = 8;
    localparam int IH = 4;
    localparam int NW = IW / P;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        sof;
    logic [31:0] din;
    logic        cwe;
    logic [3:0]  caddr;
    logic [7:0]  cdata;
    logic        ov;
    logic        ol;
    logic [31:0] od;

    always #5 clk = ~clk;

    conv3x3_stream_engine #(
        .NB_PIXEL(8), .NBF_PIXEL(7), .PIX_PER_WORD(P),
        .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH),
        .NB_COEFF(8), .NBF_COEFF(7), .NB_OUTPUT(8), .NBF_OUTPUT(7)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_sof(sof), .i_data(din),
        .i_coeff_we(cwe), .i_coeff_addr(caddr), .i_coeff_data(cdata),
        .o_valid(ov), .o_last(ol), .o_data(od)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: one record per valid output word.
    logic [31:0] got_data [$];
    logic        got_last [$];
    int          got_cyc  [$];
    always @(negedge clk) begin
        if (ov === 1'b1) begin
            got_data.push_back(od);
            got_last.push_back(ol);
            got_cyc.push_back(cyc);
            $display("[TB] out cyc=%0d data=%h last=%0b", cyc, od, ol);
        end
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    int          base;
    int          in_cyc [$];
    logic [7:0]  img  [IH][IW];
    logic [7:0]  kern [9];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack_word(input int r, input int w);
        logic [31:0] v;
        for (int k = 0; k < P; k++) v[k*8 +: 8] = img[r][w*P+k];
        return v;
    endfunction

    // Reference convolution on the 2D image for output at (row r, word w).
    function automatic logic [31:0] model_word(input int r, input int w);
        logic [31:0] v;
        int acc;
        for (int k = 0; k < P; k++) begin
            acc = 0;
            for (int dr = 0; dr < 3; dr++)
                for (int dc = 0; dc < 3; dc++)
                    acc += int'($signed(img[r-2+dr][(w-1)*P+k+dc]))
                         * int'($signed(kern[dr*3+dc]));
            acc = acc >>> 7;
            if (acc > 127)  acc = 127;
            if (acc < -128) acc = -128;
            v[k*8 +: 8] = acc[7:0];
        end
        return v;
    endfunction

    task automatic fill_const(input logic [7:0] val);
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) img[r][c] = val;
    endtask

    task automatic fill_pattern(input int seed);
        int t;
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) begin
                t = r * 53 + c * 29 + seed * 17;
                img[r][c] = t[7:0];
            end
    endtask

    task automatic send_word(input logic [31:0] d, input logic s);
        valid = 1'b1;
        sof   = s;
        din   = d;
        tick();
        valid = 1'b0;
        sof   = 1'b0;
        cwe   = 1'b0;
    endtask

    task automatic write_coeff(input logic [3:0] a, input logic [7:0] d);
        cwe   = 1'b1;
        caddr = a;
        cdata = d;
        tick();
        cwe   = 1'b0;
    endtask

    // Send one full frame; optional random stalls and one coefficient write
    // applied alongside word index cw_word (-1 = none).
    task automatic send_frame(input int stall, input int cw_word,
                              input logic [3:0] cw_a, input logic [7:0] cw_d);
        int s;
        base = got_data.size();
        in_cyc.delete();
        for (int r = 0; r < IH; r++)
            for (int w = 0; w < NW; w++) begin
                s = 0;
                while (stall != 0 && $urandom_range(0, 1) == 1 && s < 3) begin
                    tick();
                    s++;
                end
                if (r * NW + w == cw_word) begin
                    cwe = 1'b1; caddr = cw_a; cdata = cw_d;
                end
                send_word(pack_word(r, w), (r == 0 && w == 0));
                if (r >= 2 && w >= 1) in_cyc.push_back(cyc);
            end
        repeat (4) tick();
    endtask

    task automatic check_frame(input string tag, input logic [31:0] e0, input logic [31:0] e1);
        int n;
        n = got_data.size() - base;
        chk({tag, " count"}, n, 2);
        if (n == 2) begin
            chk({tag, " word0"}, got_data[base],   e0);
            chk({tag, " word1"}, got_data[base+1], e1);
            chk({tag, " last0"}, got_last[base],   1'b0);
            chk({tag, " last1"}, got_last[base+1], 1'b1);
            chk({tag, " lat0"},  got_cyc[base],    in_cyc[0] + 1);
            chk({tag, " lat1"},  got_cyc[base+1],  in_cyc[1] + 1);
        end
        $display("[TB] frame %s outputs=%0d", tag, n);
    endtask

    task automatic set_kern_identity();
        for (int i = 0; i < 9; i++) kern[i] = 8'h00;
        kern[4] = 8'h7F;
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; sof = 1'b0; din = '0;
        cwe = 1'b0; caddr = '0; cdata = '0;
        set_kern_identity();
        repeat (3) tick();
        chk("reset o_valid", ov, 1'b0);
        chk("reset o_last",  ol, 1'b0);
        chk("reset o_data",  od, 32'h0);
        rst = 1'b0;
        tick();

        // Identity kernel, flat 0x40 (0.5) -> 0x3F everywhere.
        fill_const(8'h40);
        send_frame(0, -1, 4'd0, 8'h00);
        check_frame("ident40", 32'h3F3F3F3F, 32'h3F3F3F3F);

        // All coefficients 0x7F: positive and negative saturation.
        for (int i = 0; i < 9; i++) write_coeff(4'(i), 8'h7F);
        fill_const(8'h7F);
        send_frame(0, -1, 4'd0, 8'h00);
        check_frame("satpos", 32'h7F7F7F7F, 32'h7F7F7F7F);
        fill_const(8'h80);
        send_frame(0, -1, 4'd0, 8'h00);
        check_frame("satneg", 32'h80808080, 32'h80808080);

        // Back to identity in the shadow bank, then a mid-frame centre write.
        for (int i = 0; i < 9; i++) write_coeff(4'(i), (i == 4) ? 8'h7F : 8'h00);
        fill_const(8'h40);
        send_frame(0, 3, 4'd4, 8'h40);
        check_frame("midwrite", 32'h3F3F3F3F, 32'h3F3F3F3F);
        send_frame(0, -1, 4'd0, 8'h00);
        check_frame("committed", 32'h20202020, 32'h20202020);
        // Write landing on the sof word is part of that commit.
        send_frame(0, 0, 4'd4, 8'h7F);
        check_frame("sofwrite", 32'h3F3F3F3F, 32'h3F3F3F3F);

        // Non-trivial kernel, patterned frame, random stalls.
        kern[0] = 8'h10; kern[1] = 8'hF0; kern[2] = 8'h20;
        kern[3] = 8'h08; kern[4] = 8'h7F; kern[5] = 8'hC0;
        kern[6] = 8'h00; kern[7] = 8'h30; kern[8] = 8'h81;
        for (int i = 0; i < 9; i++) write_coeff(4'(i), kern[i]);
        fill_pattern(1);
        send_frame(1, -1, 4'd0, 8'h00);
        check_frame("stall", model_word(2, 1), model_word(3, 1));

        // Words without sof while idle are dropped.
        base = got_data.size();
        for (int i = 0; i < IH * NW; i++) send_word(32'h11223344 + i, 1'b0);
        repeat (4) tick();
        chk("nosof count", got_data.size() - base, 0);

        // Partial frame into RUN, then a sof restart with a new image.
        fill_pattern(5);
        base = got_data.size();
        for (int i = 0; i < 2 * NW + 1; i++) send_word(pack_word(i / NW, i % NW), i == 0);
        fill_pattern(9);
        send_frame(0, -1, 4'd0, 8'h00);
        check_frame("restart", model_word(2, 1), model_word(3, 1));

        // Reset right after the first output word is accepted.
        fill_pattern(3);
        base = got_data.size();
        for (int i = 0; i < 2 * NW + 2; i++) send_word(pack_word(i / NW, i % NW), i == 0);
        rst = 1'b1;
        tick();
        chk("midreset o_valid", ov, 1'b0);
        rst = 1'b0;
        repeat (4) tick();
        chk("midreset count", got_data.size() - base, 0);
        // Kernel banks are back to identity after reset.
        set_kern_identity();
        fill_pattern(7);
        send_frame(0, -1, 4'd0, 8'h00);
        check_frame("postreset", model_word(2, 1), model_word(3, 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
